data_in_capture_seq: RTL and testbench

//  Capture sequencer for the 16-bit input datapath. Accepts qualified samples (in_port + in_valid)

---
 rtl/data_in_seq_pkg.sv | 26 ++
 rtl/data_in_seq_fifo.sv | 54 +++++
 rtl/data_in_capture_seq.sv | 127 ++++++++++++
 tb/tb_data_in_capture_seq.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/data_in_seq_pkg.sv
// Shared constants for the capture sequencer: register map, FSM encodings, register bit positions.
// No logic; imported by the FIFO and the top level.
package data_in_seq_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_CMD    = 2'd3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_OVF  = 2'd2;

  localparam int STAT_EMPTY_BIT = 16;
  localparam int STAT_FULL_BIT  = 17;
  localparam int STAT_OVF_BIT   = 18;
  localparam int STAT_STATE_LSB = 20;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;
  localparam int CTRL_THR_LSB    = 8;

  localparam int CMD_CLR_OVF_BIT = 0;
  localparam int CMD_FLUSH_BIT   = 1;

endpackage

// File: rtl/data_in_seq_fifo.sv
// Synchronous FIFO with flush; head is presented combinationally on dout.
// Latency: push visible in level one cycle later. Backpressure: push while full is ignored unless popping.
module data_in_seq_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     empty,
  output logic                     full
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_pop;
  logic             do_push;

  assign empty   = (level == '0);
  assign full    = (level == (PTR_W+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && !flush && do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/data_in_capture_seq.sv
// Capture sequencer: samples into a FIFO while RUN, Avalon-MM drain slave, level/overflow IRQ.
// Latency: 1-cycle registered reads; samples arriving at a full FIFO are dropped and flag overflow.
// Optional DATA_IN_TIMESTAMP_EN stores a 16-bit cycle stamp in DATA[31:16].
module data_in_capture_seq
  import data_in_seq_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              read_n,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [DATA_W-1:0] in_port,
  input  logic              in_valid,
  output logic              irq
);

  localparam int LVL_W = $clog2(DEPTH) + 1;
`ifdef DATA_IN_TIMESTAMP_EN
  localparam int ENTRY_W = 32;
`else
  localparam int ENTRY_W = DATA_W;
`endif

  logic               rd, wr;
  logic [1:0]         state;
  logic               enable, irq_en, ovf;
  logic [LVL_W-1:0]   thr;
  logic [LVL_W-1:0]   level;
  logic               empty, full;
  logic [ENTRY_W-1:0] fifo_din, fifo_dout;
  logic               fifo_push, fifo_pop, flush, clr_ovf, push_req, overflow;
  logic [31:0]        status_word, ctrl_word;
  logic               unused_wd;

  assign rd        = chipselect & ~read_n;
  assign wr        = chipselect & ~write_n;
  assign fifo_pop  = rd & (address == ADDR_DATA) & ~empty;
  assign flush     = wr & (address == ADDR_CMD) & writedata[CMD_FLUSH_BIT];
  assign clr_ovf   = wr & (address == ADDR_CMD) & writedata[CMD_CLR_OVF_BIT];
  assign push_req  = (state == ST_RUN) & in_valid;
  // Flush drops the sample outright, so it never counts as an overflow.
  assign overflow  = push_req & full & ~fifo_pop & ~flush;
  assign fifo_push = push_req & ~flush & (~full | fifo_pop);
  assign unused_wd = ^{writedata[31:CTRL_THR_LSB+LVL_W], writedata[CTRL_THR_LSB-1:2]};

`ifdef DATA_IN_TIMESTAMP_EN
  logic [15:0] ts;
  always_ff @(posedge clk) begin
    if (!reset_n) ts <= '0;
    else          ts <= ts + 1'b1;
  end
  assign fifo_din = {ts, 16'(in_port)};
`else
  assign fifo_din = in_port;
`endif

  data_in_seq_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .flush   (flush),
    .din     (fifo_din),
    .dout    (fifo_dout),
    .level   (level),
    .empty   (empty),
    .full    (full)
  );

  always_comb begin
    status_word = '0;
    status_word[LVL_W-1:0]            = level;
    status_word[STAT_EMPTY_BIT]       = empty;
    status_word[STAT_FULL_BIT]        = full;
    status_word[STAT_OVF_BIT]         = ovf;
    status_word[STAT_STATE_LSB +: 2]  = state;
    ctrl_word = '0;
    ctrl_word[CTRL_EN_BIT]            = enable;
    ctrl_word[CTRL_IRQ_EN_BIT]        = irq_en;
    ctrl_word[CTRL_THR_LSB +: LVL_W]  = thr;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      readdata <= '0;
      enable   <= 1'b0;
      irq_en   <= 1'b0;
      thr      <= '0;
      ovf      <= 1'b0;
      state    <= ST_IDLE;
      irq      <= 1'b0;
    end else begin
      if (rd) begin
        case (address)
          ADDR_DATA:   readdata <= empty ? 32'd0 : 32'(fifo_dout);
          ADDR_STATUS: readdata <= status_word;
          ADDR_CTRL:   readdata <= ctrl_word;
          default:     readdata <= 32'd0;
        endcase
      end
      if (wr && address == ADDR_CTRL) begin
        enable <= writedata[CTRL_EN_BIT];
        irq_en <= writedata[CTRL_IRQ_EN_BIT];
        thr    <= writedata[CTRL_THR_LSB +: LVL_W];
      end
      if (overflow)     ovf <= 1'b1;
      else if (clr_ovf) ovf <= 1'b0;
      case (state)
        ST_IDLE: if (enable) state <= ST_RUN;
        ST_RUN: begin
          if (overflow)     state <= ST_OVF;
          else if (!enable) state <= ST_IDLE;
        end
        ST_OVF:  if (!ovf) state <= enable ? ST_RUN : ST_IDLE;
        default: state <= ST_IDLE;
      endcase
      irq <= irq_en & (((thr != '0) & (level >= thr)) | ovf);
    end
  end

endmodule

// File: tb/tb_data_in_capture_seq.sv
// Scoreboard bench: bus reads queue their expected readdata; a monitor checks on the following negedge.
module tb_data_in_capture_seq;
  import data_in_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        read_n = 1'b1;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [15:0] in_port = 16'd0;
  logic        in_valid = 1'b0;
  logic        irq;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];
  logic [15:0] ts_q[$];
  logic        rd_fire = 1'b0;

  always #5 clk = ~clk;

  data_in_capture_seq dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .read_n     (read_n),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .in_valid   (in_valid),
    .irq        (irq)
  );

`ifdef DATA_IN_TIMESTAMP_EN
  logic [15:0] tb_ts = 16'd0;
  always @(posedge clk) begin
    if (!reset_n) tb_ts <= 16'd0;
    else          tb_ts <= tb_ts + 16'd1;
  end
`endif

  always @(posedge clk) rd_fire <= reset_n & chipselect & ~read_n;

  initial begin : monitor
    logic [31:0] e;
    string       n;
    forever begin
      @(negedge clk);
      if (rd_fire === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_read got=%h exp=none", readdata);
        end else begin
          e = exp_q.pop_front();
          n = name_q.pop_front();
          if (readdata !== e) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", n, readdata, e);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", n, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] st(input int lvl, input bit emp, input bit ful,
                                     input bit ov, input logic [1:0] s);
    return 32'(lvl) | (32'(emp) << 16) | (32'(ful) << 17) | (32'(ov) << 18) | (32'(s) << 20);
  endfunction

  function automatic logic [15:0] cur_ts();
`ifdef DATA_IN_TIMESTAMP_EN
    return tb_ts;
`else
    return 16'd0;
`endif
  endfunction

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    step(1);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd_reg(input logic [1:0] a, input logic [31:0] exp, input string n);
    address = a; chipselect = 1'b1; read_n = 1'b0;
    exp_q.push_back(exp); name_q.push_back(n);
    step(1);
    chipselect = 1'b0; read_n = 1'b1;
  endtask

  task automatic rd_data(input logic [15:0] s, input string n);
    logic [15:0] t;
    t = ts_q.pop_front();
    rd_reg(ADDR_DATA, {t, s}, n);
  endtask

  task automatic push(input logic [15:0] s, input bit accept);
    in_port = s; in_valid = 1'b1;
    if (accept) ts_q.push_back(cur_ts());
    step(1);
    in_valid = 1'b0;
  endtask

  initial begin
    // 1: reset with random activity on the inputs
    repeat (3) begin
      in_valid = 1'($urandom); in_port = 16'($urandom);
      step(1);
    end
    in_valid = 1'b0;
    reset_n = 1'b1;
    check("reset_readdata", readdata, 32'd0);
    check("reset_irq", {31'd0, irq}, 32'd0);
    rd_reg(ADDR_STATUS, 32'h0001_0000, "reset_status");

    // 2: basic capture and ordered drain
    wr_reg(ADDR_CTRL, 32'h1);
    step(1);
    push(16'h1111, 1); push(16'h2222, 1); push(16'h3333, 1);
    rd_reg(ADDR_STATUS, st(3, 0, 0, 0, ST_RUN), "run_status_lvl3");
    rd_data(16'h1111, "data0");
    rd_data(16'h2222, "data1");
    rd_data(16'h3333, "data2");
    rd_reg(ADDR_DATA, 32'd0, "data_empty");
    rd_reg(ADDR_STATUS, st(0, 1, 0, 0, ST_RUN), "status_empty");
    rd_reg(ADDR_CTRL, 32'h1, "ctrl_readback");

    // 3: threshold IRQ
    wr_reg(ADDR_CTRL, 32'h0403);
    push(16'hA001, 1); push(16'hA002, 1); push(16'hA003, 1); push(16'hA004, 1);
    check("irq_lags_level", {31'd0, irq}, 32'd0);
    step(1);
    check("irq_thr_rise", {31'd0, irq}, 32'd1);
    rd_data(16'hA001, "thr_pop");
    check("irq_hold", {31'd0, irq}, 32'd1);
    step(1);
    check("irq_thr_fall", {31'd0, irq}, 32'd0);

    // 4: overflow with level term disabled
    wr_reg(ADDR_CTRL, 32'h3);
    step(1);
    for (int i = 0; i < 13; i++) push(16'hB000 + 16'(i), 1);
    check("irq_thr0", {31'd0, irq}, 32'd0);
    push(16'hBEEF, 0);
    rd_reg(ADDR_STATUS, st(16, 0, 1, 1, ST_OVF), "ovf_status");
    check("irq_ovf", {31'd0, irq}, 32'd1);
    wr_reg(ADDR_CMD, 32'h1);
    step(1);
    rd_reg(ADDR_STATUS, st(16, 0, 1, 0, ST_RUN), "ovf_cleared");
    check("irq_ovf_clr", {31'd0, irq}, 32'd0);

    // 5: push+pop while full, then drain and flush-with-push
    begin
      logic [15:0] t;
      t = ts_q.pop_front();
      in_port = 16'hC0DE; in_valid = 1'b1;
      address = ADDR_DATA; chipselect = 1'b1; read_n = 1'b0;
      exp_q.push_back({t, 16'hA002}); name_q.push_back("full_pushpop_data");
      ts_q.push_back(cur_ts());
      step(1);
      in_valid = 1'b0; chipselect = 1'b0; read_n = 1'b1;
    end
    rd_reg(ADDR_STATUS, st(16, 0, 1, 0, ST_RUN), "full_pushpop_status");
    rd_data(16'hA003, "drain_a3");
    rd_data(16'hA004, "drain_a4");
    for (int i = 0; i < 13; i++) rd_data(16'hB000 + 16'(i), "drain_b");
    rd_data(16'hC0DE, "drain_c0de");
    rd_reg(ADDR_DATA, 32'd0, "drain_empty");
    push(16'hD001, 1); push(16'hD002, 1);
    in_port = 16'hD003; in_valid = 1'b1;
    wr_reg(ADDR_CMD, 32'h2);
    in_valid = 1'b0;
    ts_q.delete();
    rd_reg(ADDR_STATUS, st(0, 1, 0, 0, ST_RUN), "flush_status");

    // 6: reset mid-drain, then timestamped capture
    push(16'hE001, 1); push(16'hE002, 1);
    rd_data(16'hE001, "pre_reset_data");
    wr_reg(ADDR_CTRL, 32'h0103);
    step(2);
    check("pre_reset_irq", {31'd0, irq}, 32'd1);
    reset_n = 1'b0; in_valid = 1'b1; in_port = 16'h5A5A;
    step(1);
    reset_n = 1'b1; in_valid = 1'b0;
    ts_q.delete();
    check("rst2_readdata", readdata, 32'd0);
    check("rst2_irq", {31'd0, irq}, 32'd0);
    rd_reg(ADDR_STATUS, 32'h0001_0000, "rst2_status");
    wr_reg(ADDR_CTRL, 32'h1);
    step(4);
    push(16'hF00D, 1);
    rd_data(16'hF00D, "ts_data");

    step(2);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
